// File: rtl/assoc_cache_ctrl_if.sv
// assoc_cache_ctrl_if: core request/response, memory handshake and counter bundle for assoc_cache_ctrl.
// The master side is the core plus memory environment; the slave side is the controller.
interface assoc_cache_ctrl_if #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_hit;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic              cnt_clr;
    logic [CNT_W-1:0]  hit_count;
    logic [CNT_W-1:0]  access_count;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_ack, mem_rdata, cnt_clr,
        input  req_ready, rsp_valid, rsp_rdata, rsp_hit, mem_req, mem_we, mem_addr, mem_wdata,
               hit_count, access_count
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_ack, mem_rdata, cnt_clr,
        output req_ready, rsp_valid, rsp_rdata, rsp_hit, mem_req, mem_we, mem_addr, mem_wdata,
               hit_count, access_count
    );
endinterface

// File: rtl/assoc_cache_ctrl.sv
// assoc_cache_ctrl: N-way set-associative write-through, no-write-allocate cache with
// round-robin replacement, request/memory handshakes and saturating hit/access counters.
module assoc_cache_ctrl #(
    parameter int ADDR_W  = 6,
    parameter int DATA_W  = 8,
    parameter int INDEX_W = 3,
    parameter int WAYS    = 2,
    parameter int CNT_W   = 8
) (
    input logic              clk,
    input logic              reset,
    assoc_cache_ctrl_if.slave bus
);
    localparam int SETS  = 2 ** INDEX_W;
    localparam int TAG_W = ADDR_W - INDEX_W;
    localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_MISS, S_WRITE, S_RESP} state_t;

    state_t            r_state;
    logic              r_req_ready;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_hit;
    logic              r_rsp_valid;
    logic              r_rsp_hit;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_mem_req;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [CNT_W-1:0]  r_hit_cnt;
    logic [CNT_W-1:0]  r_acc_cnt;
    logic [WAYS-1:0]   r_valid [SETS];
    logic [WAY_W-1:0]  r_rr    [SETS];
    logic [TAG_W-1:0]  r_tag   [SETS][WAYS];
    logic [DATA_W-1:0] r_data  [SETS][WAYS];

    logic [INDEX_W-1:0] w_set;
    logic [TAG_W-1:0]   w_tag;
    logic               w_hit;
    logic [WAY_W-1:0]   w_way;
    logic [WAY_W-1:0]   w_vic;

    assign w_set = r_addr[INDEX_W-1:0];
    assign w_tag = r_addr[ADDR_W-1:INDEX_W];

    always_comb begin
        w_hit = 1'b0;
        w_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (r_valid[w_set][w] && r_tag[w_set][w] == w_tag) begin
                w_hit = 1'b1;
                w_way = WAY_W'(w);
            end
        end
    end

    // Descending scan so the lowest-index invalid way wins; rr pointer only when the set is full.
    always_comb begin
        w_vic = r_rr[w_set];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!r_valid[w_set][w]) w_vic = WAY_W'(w);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_req_ready <= 1'b1;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_hit       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_hit   <= 1'b0;
            r_rsp_rdata <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_hit_cnt   <= '0;
            r_acc_cnt   <= '0;
            for (int s = 0; s < SETS; s++) begin
                r_valid[s] <= '0;
                r_rr[s]    <= '0;
            end
        end else begin
            r_rsp_valid <= 1'b0;
            if (bus.cnt_clr) begin
                r_hit_cnt <= '0;
                r_acc_cnt <= '0;
            end else if (r_state == S_RESP) begin
                r_acc_cnt <= (r_acc_cnt == '1) ? r_acc_cnt : r_acc_cnt + 1'b1;
                r_hit_cnt <= (r_rsp_hit && r_hit_cnt != '1) ? r_hit_cnt + 1'b1 : r_hit_cnt;
            end
            case (r_state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        r_we        <= bus.req_we;
                        r_addr      <= bus.req_addr;
                        r_wdata     <= bus.req_wdata;
                        r_req_ready <= 1'b0;
                        r_state     <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    r_hit <= w_hit;
                    if (!r_we && w_hit) begin
                        r_rsp_valid <= 1'b1;
                        r_rsp_hit   <= 1'b1;
                        r_rsp_rdata <= r_data[w_set][w_way];
                        r_state     <= S_RESP;
                    end else begin
                        r_mem_req  <= 1'b1;
                        r_mem_we   <= r_we;
                        r_mem_addr <= r_addr;
                        if (r_we) r_mem_wdata <= r_wdata;
                        r_state <= r_we ? S_WRITE : S_MISS;
                    end
                end
                S_MISS: begin
                    if (bus.mem_ack) begin
                        r_mem_req            <= 1'b0;
                        r_rsp_valid          <= 1'b1;
                        r_rsp_hit            <= 1'b0;
                        r_rsp_rdata          <= bus.mem_rdata;
                        r_valid[w_set][w_vic] <= 1'b1;
                        if (&r_valid[w_set]) r_rr[w_set] <= WAY_W'((32'(r_rr[w_set]) + 1) % WAYS);
                        r_state <= S_RESP;
                    end
                end
                S_WRITE: begin
                    if (bus.mem_ack) begin
                        r_mem_req   <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_rsp_hit   <= r_hit;
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    r_req_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Tag/data storage carries no reset; valid bits gate every use.
    always_ff @(posedge clk) begin
        if (r_state == S_LOOKUP && r_we && w_hit) begin
            r_data[w_set][w_way] <= r_wdata;
        end else if (r_state == S_MISS && bus.mem_ack) begin
            r_tag[w_set][w_vic]  <= w_tag;
            r_data[w_set][w_vic] <= bus.mem_rdata;
        end
    end

    assign bus.req_ready    = r_req_ready;
    assign bus.rsp_valid    = r_rsp_valid;
    assign bus.rsp_rdata    = r_rsp_rdata;
    assign bus.rsp_hit      = r_rsp_hit;
    assign bus.mem_req      = r_mem_req;
    assign bus.mem_we       = r_mem_we;
    assign bus.mem_addr     = r_mem_addr;
    assign bus.mem_wdata    = r_mem_wdata;
    assign bus.hit_count    = r_hit_cnt;
    assign bus.access_count = r_acc_cnt;
endmodule

// File: tb/tb_assoc_cache_ctrl.sv
// tb_assoc_cache_ctrl: directed scenarios plus randomized traffic checked against a
// transaction-level cache model and a RAM array living in the bench.
module tb_assoc_cache_ctrl;
    localparam int ADDR_W  = 6;
    localparam int DATA_W  = 8;
    localparam int INDEX_W = 3;
    localparam int WAYS    = 2;
    localparam int CNT_W   = 4;
    localparam int SETS    = 2 ** INDEX_W;
    localparam int MAXC    = 2 ** CNT_W - 1;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    assoc_cache_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    assoc_cache_ctrl #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .INDEX_W(INDEX_W), .WAYS(WAYS), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [DATA_W-1:0] mem    [2**ADDR_W];
    bit                m_valid[SETS][WAYS];
    int                m_tag  [SETS][WAYS];
    logic [DATA_W-1:0] m_data [SETS][WAYS];
    int                m_rr   [SETS];
    int                m_hit;
    int                m_acc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < SETS; s++) begin
            m_rr[s] = 0;
            for (int w = 0; w < WAYS; w++) m_valid[s][w] = 1'b0;
        end
        m_hit = 0;
        m_acc = 0;
    endtask

    task automatic do_req(input bit we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input int dly, input bit clr);
        int set, tg, hw, vic, n, wcnt;
        bit eh, seen, acked;
        logic [DATA_W-1:0] er;
        set = int'(a) % SETS;
        tg  = int'(a) / SETS;
        hw  = -1;
        er  = '0;
        for (int w = 0; w < WAYS; w++) if (m_valid[set][w] && m_tag[set][w] == tg) hw = w;
        eh = (hw >= 0);
        if (we) begin
            if (eh) m_data[set][hw] = d;
        end else if (eh) begin
            er = m_data[set][hw];
        end else begin
            er  = mem[a];
            vic = -1;
            for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[set][w]) vic = w;
            if (vic < 0) begin
                vic = m_rr[set];
                m_rr[set] = (m_rr[set] + 1) % WAYS;
            end
            m_valid[set][vic] = 1'b1;
            m_tag[set][vic]   = tg;
            m_data[set][vic]  = er;
        end
        @(negedge clk);
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_before", bus.req_ready, 1);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = a;
        bus.req_wdata = d;
        @(negedge clk);
        bus.req_valid = 1'b0;
        n = 1;
        seen = 0;
        acked = 0;
        wcnt = 0;
        while (!bus.rsp_valid && n < 50) begin
            bus.mem_ack = 1'b0;
            if (seen && !acked) check("mem_req_hold", bus.mem_req, 1);
            if (bus.mem_req && !acked) begin
                if (!seen) begin
                    seen = 1;
                    check("mem_we", bus.mem_we, we);
                    check("mem_addr", bus.mem_addr, a);
                    if (we) check("mem_wdata", bus.mem_wdata, d);
                end
                if (wcnt == dly) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = mem[bus.mem_addr];
                    if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
                    acked = 1;
                end else begin
                    wcnt++;
                end
            end
            @(negedge clk);
            n++;
        end
        bus.mem_ack = 1'b0;
        check("rsp_valid", bus.rsp_valid, 1);
        check("rsp_hit", bus.rsp_hit, eh);
        check("mem_used", seen, we || !eh);
        check("mem_req_after", bus.mem_req, 0);
        if (!we) check("rsp_rdata", bus.rsp_rdata, er);
        if (!we && eh) check("hit_latency", n, 2);
        if (clr) bus.cnt_clr = 1'b1;
        @(negedge clk);
        bus.cnt_clr = 1'b0;
        if (clr) begin
            m_acc = 0;
            m_hit = 0;
        end else begin
            m_acc = (m_acc == MAXC) ? MAXC : m_acc + 1;
            if (eh) m_hit = (m_hit == MAXC) ? MAXC : m_hit + 1;
        end
        check("rsp_pulse", bus.rsp_valid, 0);
        check("req_ready_after", bus.req_ready, 1);
        check("access_count", bus.access_count, m_acc);
        check("hit_count", bus.hit_count, m_hit);
    endtask

    initial begin
        reset = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
        bus.cnt_clr   = 1'b0;
        for (int i = 0; i < 2**ADDR_W; i++) mem[i] = DATA_W'($urandom);
        mem[5] = 8'h3C;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_req_ready", bus.req_ready, 1);
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_rsp_hit", bus.rsp_hit, 0);
        check("rst_rsp_rdata", bus.rsp_rdata, 0);
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_hit_count", bus.hit_count, 0);
        check("rst_access_count", bus.access_count, 0);
        reset = 1'b0;
        // Miss fill then 2-cycle hit; set-5 eviction order; write-through hit/miss.
        do_req(0, 6'h05, 8'h00, 1, 0);
        do_req(0, 6'h05, 8'h00, 0, 0);
        do_req(0, 6'h0D, 8'h00, 2, 0);
        do_req(0, 6'h15, 8'h00, 0, 0);
        do_req(0, 6'h0D, 8'h00, 0, 0);
        do_req(0, 6'h05, 8'h00, 1, 0);
        do_req(0, 6'h0D, 8'h00, 0, 0);
        do_req(1, 6'h0D, 8'hA5, 1, 0);
        do_req(0, 6'h0D, 8'h00, 0, 0);
        do_req(1, 6'h20, 8'h11, 0, 0);
        do_req(0, 6'h20, 8'h00, 3, 0);
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 8'hFF;
        repeat (3) begin
            @(negedge clk);
            check("idle_ack_mem_req", bus.mem_req, 0);
            check("idle_ack_rsp", bus.rsp_valid, 0);
        end
        bus.mem_ack = 1'b0;
        do_req(0, 6'h20, 8'h00, 0, 0);
        for (int i = 0; i < 20; i++) do_req(0, 6'h0D, 8'h00, 0, 0);
        check("sat_access", bus.access_count, MAXC);
        check("sat_hit", bus.hit_count, MAXC);
        do_req(0, 6'h0D, 8'h00, 0, 1);
        // Reset while a read miss waits on memory.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 6'h2E;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("abort_mem_req_pre", bus.mem_req, 1);
        reset = 1'b1;
        #1;
        check("abort_mem_req", bus.mem_req, 0);
        check("abort_req_ready", bus.req_ready, 1);
        check("abort_rsp_valid", bus.rsp_valid, 0);
        @(negedge clk);
        check("abort_no_rsp", bus.rsp_valid, 0);
        reset = 1'b0;
        model_reset();
        do_req(0, 6'h0D, 8'h00, 0, 0);
        for (int i = 0; i < 300; i++) begin
            do_req(1'($urandom_range(0, 3) == 0),
                   ADDR_W'(($urandom_range(0, 3) << INDEX_W) | $urandom_range(4, 6)),
                   DATA_W'($urandom), $urandom_range(0, 3), $urandom_range(0, 40) == 0);
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
